// File: rtl/magic_side_scan_ctrl.sv
// Cube-face capture sequencer: steps sticker positions per face, fetches each
// colour from the classifier and hands it to the side data-set block.
module magic_side_scan_ctrl #(
  parameter int unsigned NUM_FACES    = 6,
  parameter int unsigned POS_PER_FACE = 9,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       colour_req,
  output logic [3:0] sample_pos,
  output logic [2:0] sample_face,
  input  logic       colour_valid,
  input  logic [2:0] colour_in,
  output logic       set_enable,
  output logic [8:0] position_coding,
  output logic [2:0] color_coding,
  input  logic       set_done,
  output logic       face_done,
  output logic       all_done,
  output logic       busy,
  output logic       error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_SET      = 3'd2;
  localparam logic [2:0] S_WAIT_SET = 3'd3;
  localparam logic [2:0] S_ADV      = 3'd4;
  localparam logic [2:0] S_FACE_END = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [2:0]    face_q, face_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [8:0]    pcode_q, pcode_d;
  logic [2:0]    ccode_q, ccode_d;
  logic          error_q, error_d;
  logic          timer_expired;

  // Timer reaches its limit on the TIMEOUT_CYC-th cycle spent in a wait state.
  assign timer_expired = (timer_q == TW'(TIMEOUT_CYC - 1));

  // Next-state, counters, timer and latched codes.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    face_d  = face_q;
    timer_d = '0;
    pcode_d = pcode_q;
    ccode_d = ccode_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          error_d = 1'b0;
          pos_d   = 4'd1;
          face_d  = '0;
        end
      end
      S_REQ: begin
        // A result arriving on the expiry cycle still counts.
        if (colour_valid) begin
          ccode_d = colour_in;
          pcode_d = {5'd0, pos_q};
          state_d = S_SET;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SET: state_d = S_WAIT_SET;
      S_WAIT_SET: begin
        if (set_done) begin
          state_d = S_ADV;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ADV: begin
        if (pos_q < 4'(POS_PER_FACE)) begin
          pos_d   = pos_q + 4'd1;
          state_d = S_REQ;
        end else begin
          state_d = S_FACE_END;
        end
      end
      S_FACE_END: begin
        if (face_q < 3'(NUM_FACES - 1)) begin
          face_d  = face_q + 3'd1;
          pos_d   = 4'd1;
          state_d = S_REQ;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides every transition above but leaves the error flag alone.
    if (abort) begin
      state_d = S_IDLE;
      error_d = error_q;
      timer_d = '0;
    end

    if (state_d == S_IDLE) begin
      pcode_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pos_q   <= 4'd1;
      face_q  <= '0;
      timer_q <= '0;
      pcode_q <= '0;
      ccode_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      face_q  <= face_d;
      timer_q <= timer_d;
      pcode_q <= pcode_d;
      ccode_q <= ccode_d;
      error_q <= error_d;
    end
  end

  // Strobes decode directly from the state register.
  always_comb begin
    colour_req      = (state_q == S_REQ);
    set_enable      = (state_q == S_SET);
    face_done       = (state_q == S_FACE_END);
    all_done        = (state_q == S_FINISH);
    busy            = (state_q != S_IDLE);
    sample_pos      = pos_q;
    sample_face     = face_q;
    position_coding = pcode_q;
    color_coding    = ccode_q;
    error           = error_q;
  end

endmodule

// File: tb/tb_magic_side_scan_ctrl.sv
// Directed bench for magic_side_scan_ctrl with a cycle-level classifier and
// data-set block responder.
module tb_magic_side_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, colour_valid, set_done;
  logic [2:0] colour_in;
  logic       colour_req, set_enable, face_done, all_done, busy, error;
  logic [3:0] sample_pos;
  logic [2:0] sample_face;
  logic [8:0] position_coding;
  logic [2:0] color_coding;

  int checks   = 0;
  int failures = 0;

  // Results recorded by drive_run
  int n_set, n_face, n_all, seq_err, face_err;
  int t_hold, t_err, t_abort, t_all, t_end;
  int err_at0;
  bit end_req, end_set, end_err, ended;

  localparam int MAXC = 2000;

  magic_side_scan_ctrl #(
    .NUM_FACES   (6),
    .POS_PER_FACE(9),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .colour_req     (colour_req),
    .sample_pos     (sample_pos),
    .sample_face    (sample_face),
    .colour_valid   (colour_valid),
    .colour_in      (colour_in),
    .set_enable     (set_enable),
    .position_coding(position_coding),
    .color_coding   (color_coding),
    .set_done       (set_done),
    .face_done      (face_done),
    .all_done       (all_done),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Runs one scan; classifier and set block answer one cycle late.
  // hold_*: withhold set_done for that face/pos; abort_*: abort in its WAIT_SET.
  task automatic drive_run(input int hold_face, input int hold_pos,
                           input int abort_face, input int abort_pos,
                           input bit stray);
    int exp_pos, exp_face, req_age, set_age, set_pos, set_face;
    bit hold;
    exp_pos = 1; exp_face = 0; req_age = 0; set_age = 0;
    set_pos = 0; set_face = 0; hold = 0;
    n_set = 0; n_face = 0; n_all = 0; seq_err = 0; face_err = 0;
    t_hold = -1; t_err = -1; t_abort = -1; t_all = -1; t_end = -1;
    err_at0 = -1; ended = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; set_done = 1'b0; colour_valid = 1'b0; abort = 1'b0;
      if (cyc == 0) err_at0 = int'(error);
      if (error && t_err < 0) t_err = cyc;
      if (cyc > 0 && !busy) begin
        t_end = cyc; end_req = colour_req; end_set = set_enable;
        end_err = error; ended = 1;
        break;
      end
      if (all_done) begin n_all++; t_all = cyc; end
      if (face_done) begin
        if (sample_face !== 3'(n_face)) face_err++;
        n_face++;
      end
      if (set_enable) begin
        if (position_coding !== 9'(exp_pos)) seq_err++;
        if (color_coding !== 3'(exp_pos)) seq_err++;
        if (sample_face !== 3'(exp_face)) seq_err++;
        if (sample_pos !== 4'(exp_pos)) seq_err++;
        n_set++;
        set_pos = exp_pos; set_face = exp_face; set_age = 1;
        if (exp_face == hold_face && exp_pos == hold_pos) begin
          hold = 1; t_hold = cyc;
        end
        exp_pos++;
        if (exp_pos > 9) begin exp_pos = 1; exp_face++; end
      end else if (set_age > 0) begin
        set_age++;
      end
      req_age = colour_req ? req_age + 1 : 0;
      colour_valid = (req_age == 2);
      colour_in = colour_valid ? 3'(exp_pos) : ~3'(exp_pos);
      if (set_age == 3 && !hold) begin set_done = 1'b1; set_age = 0; end
      if (stray && req_age == 1 && exp_face == 0 && exp_pos == 3) begin
        set_done = 1'b1; start = 1'b1;
      end
      if (set_age == 2 && set_face == abort_face && set_pos == abort_pos) begin
        abort = 1'b1; t_abort = cyc;
      end
    end
    start = 1'b0; set_done = 1'b0; colour_valid = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (sample_pos !== 4'd1) begin failures++; $display("FAIL reset_pos got=%0d want=1", sample_pos); end
    checks++; if (sample_face !== 3'd0) begin failures++; $display("FAIL reset_face got=%0d want=0", sample_face); end
    checks++; if ({colour_req, set_enable, face_done, all_done, error} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b want=00000", {colour_req, set_enable, face_done, all_done, error});
    end
    checks++; if ({position_coding, color_coding} !== 12'd0) begin
      failures++; $display("FAIL reset_codes got=%h want=000", {position_coding, color_coding});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_full(input string tag);
    checks++; if (!ended) begin failures++; $display("FAIL %s_timeout ended=0 want=1", tag); end
    checks++; if (n_set != 54) begin failures++; $display("FAIL %s_nset got=%0d want=54", tag, n_set); end
    checks++; if (seq_err != 0) begin failures++; $display("FAIL %s_seq got=%0d want=0", tag, seq_err); end
    checks++; if (n_face != 6 || face_err != 0) begin
      failures++; $display("FAIL %s_faces got=%0d bad=%0d want=6/0", tag, n_face, face_err);
    end
    checks++; if (n_all != 1) begin failures++; $display("FAIL %s_all got=%0d want=1", tag, n_all); end
    checks++; if (t_all != 330 || t_end != 331) begin
      failures++; $display("FAIL %s_timing all=%0d end=%0d want=330/331", tag, t_all, t_end);
    end
    checks++; if (end_err !== 1'b0 || err_at0 != 0) begin
      failures++; $display("FAIL %s_error end=%b at0=%0d want=0/0", tag, end_err, err_at0);
    end
  endtask

  task automatic test_full_run();
    drive_run(-1, -1, -1, -1, 1'b0);
    check_full("full");
  endtask

  task automatic test_back_to_back_ignored();
    drive_run(-1, -1, -1, -1, 1'b1);
    check_full("stray");
  endtask

  task automatic test_timeout();
    drive_run(2, 5, -1, -1, 1'b0);
    checks++; if (n_set != 23) begin failures++; $display("FAIL to_nset got=%0d want=23", n_set); end
    checks++; if (n_face != 2 || n_all != 0) begin
      failures++; $display("FAIL to_done got=%0d/%0d want=2/0", n_face, n_all);
    end
    checks++; if (t_err - t_hold != 256) begin
      failures++; $display("FAIL to_latency got=%0d want=256", t_err - t_hold);
    end
    checks++; if (!ended || end_err !== 1'b1 || t_end != t_err) begin
      failures++; $display("FAIL to_idle ended=%0d err=%b end=%0d errc=%0d", ended, end_err, t_end, t_err);
    end
    checks++; if (seq_err != 0) begin failures++; $display("FAIL to_seq got=%0d want=0", seq_err); end
  endtask

  task automatic test_rescan_after_error();
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL sticky_error got=%b want=1", error); end
    drive_run(-1, -1, -1, -1, 1'b0);
    check_full("rescan");
  endtask

  task automatic test_abort();
    drive_run(-1, -1, 3, 4, 1'b0);
    checks++; if (n_set != 31 || n_face != 3 || n_all != 0) begin
      failures++; $display("FAIL abort_counts got=%0d/%0d/%0d want=31/3/0", n_set, n_face, n_all);
    end
    checks++; if (!ended || t_end != t_abort + 1) begin
      failures++; $display("FAIL abort_idle end=%0d want=%0d", t_end, t_abort + 1);
    end
    checks++; if ({end_req, end_set, end_err} !== 3'b000) begin
      failures++; $display("FAIL abort_outputs got=%b want=000", {end_req, end_set, end_err});
    end
    checks++; if (position_coding !== 9'd0) begin
      failures++; $display("FAIL abort_pcode got=%0d want=0", position_coding);
    end
  endtask

  task automatic test_rst_in_set();
    bit seen;
    seen = 0;
    colour_in = 3'd5; colour_valid = 1'b1; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (set_enable) begin seen = 1; break; end
    end
    colour_valid = 1'b0;
    checks++; if (!seen || position_coding !== 9'd1 || color_coding !== 3'd5) begin
      failures++; $display("FAIL rst_set_entry seen=%0d pcode=%0d ccode=%0d want=1/1/5", seen, position_coding, color_coding);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({set_enable, busy, colour_req} !== 3'b000) begin
      failures++; $display("FAIL rst_set_strobes got=%b want=000", {set_enable, busy, colour_req});
    end
    checks++; if (position_coding !== 9'd0 || color_coding !== 3'd0 || sample_pos !== 4'd1) begin
      failures++; $display("FAIL rst_set_codes got=%0d/%0d/%0d want=0/0/1", position_coding, color_coding, sample_pos);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; colour_valid = 1'b0;
    set_done = 1'b0; colour_in = '0;
    test_reset();
    test_full_run();
    test_back_to_back_ignored();
    test_timeout();
    test_rescan_after_error();
    test_abort();
    test_rst_in_set();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
